// File: rtl/countdown_timer_if.sv
// Control and display bundle for the two-digit BCD countdown timer.
// The master side drives Start/Pause/Load*, the slave side (timer) drives digits and status.
interface countdown_timer_if;
  logic       Start;
  logic       Pause;
  logic [3:0] LoadTens;
  logic [3:0] LoadOnes;
  logic [3:0] OnesValue;
  logic [3:0] TensValue;
  logic       Running;
  logic       Expired;
  logic       TimeUp;

  modport master (
    output Start, Pause, LoadTens, LoadOnes,
    input  OnesValue, TensValue, Running, Expired, TimeUp
  );

  modport slave (
    input  Start, Pause, LoadTens, LoadOnes,
    output OnesValue, TensValue, Running, Expired, TimeUp
  );
endinterface

// File: rtl/countdown_timer.sv
// Game countdown timer: loads a two-digit BCD time and counts it down once per
// CLOCK_FREQUENCY cycles, flagging expiry (Expired level, TimeUp pulse) at 00.
module countdown_timer #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned DIV_WIDTH       = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1
) (
  input  logic               ClockIn,
  input  logic               Reset,
  countdown_timer_if.slave   bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_RELOAD = DIV_WIDTH'(CLOCK_FREQUENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           ones_q, ones_d;
  logic [3:0]           tens_q, tens_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 running_q, running_d;
  logic                 expired_q, expired_d;
  logic                 timeup_q, timeup_d;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    div_d     = div_q;
    timeup_d  = 1'b0;

    if (bus.Start) begin
      ones_d = clamp_bcd(bus.LoadOnes);
      tens_d = clamp_bcd(bus.LoadTens);
      div_d  = DIV_RELOAD;
      if (ones_d == 4'd0 && tens_d == 4'd0) begin
        state_d  = DONE;
        timeup_d = 1'b1;
      end else begin
        state_d = bus.Pause ? PAUSED : RUN;
      end
    end else begin
      unique case (state_q)
        // The edge that leaves PAUSED already counts as a run cycle, so a pause
        // neither adds nor drops divider cycles.
        RUN, PAUSED: begin
          if (bus.Pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (div_q != '0) begin
              div_d = div_q - 1'b1;
            end else begin
              div_d = DIV_RELOAD;
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
              if (ones_d == 4'd0 && tens_d == 4'd0) begin
                state_d  = DONE;
                timeup_d = 1'b1;
              end
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      tens_q    <= '0;
      div_q     <= DIV_RELOAD;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      timeup_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      div_q     <= div_d;
      running_q <= running_d;
      expired_q <= expired_d;
      timeup_q  <= timeup_d;
    end
  end

  assign bus.OnesValue = ones_q;
  assign bus.TensValue = tens_q;
  assign bus.Running   = running_q;
  assign bus.Expired   = expired_q;
  assign bus.TimeUp    = timeup_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLOCK_FREQUENCY=4 (one tick per 4 cycles).
module tb_countdown_timer;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_pass;

  countdown_timer_if ifc ();

  countdown_timer #(.CLOCK_FREQUENCY(4)) dut (
    .ClockIn (clk),
    .Reset   (rst),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Status: {Running, Expired, TimeUp}
  function automatic logic [2:0] status();
    return {ifc.Running, ifc.Expired, ifc.TimeUp};
  endfunction

  function automatic logic [7:0] value();
    return {ifc.TensValue, ifc.OnesValue};
  endfunction

  task automatic start(input logic [3:0] t, input logic [3:0] o);
    ifc.LoadTens = t;
    ifc.LoadOnes = o;
    ifc.Start    = 1'b1;
    step(1);
    ifc.Start    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    ifc.Start = 1'b0;
    ifc.Pause = 1'b0;
    ifc.LoadTens = 4'd0;
    ifc.LoadOnes = 4'd0;

    #2;
    check("rst_val", value(), 8'h00);
    check("rst_status", status(), 3'b000);
    step(2);
    rst = 1'b0;
    step(1);
    check("idle_val", value(), 8'h00);
    check("idle_status", status(), 3'b000);

    // 12 counts down to 00, one step per 4 cycles, TimeUp 48 cycles after Start.
    start(4'd1, 4'd2);
    check("t1_load", value(), 8'h12);
    check("t1_status", status(), 3'b100);
    for (int k = 1; k <= 12; k++) begin
      step(3);
      check("t1_hold", value(), 8'({4'((13 - k) / 10), 4'((13 - k) % 10)}));
      step(1);
      check("t1_tick", value(), 8'({4'((12 - k) / 10), 4'((12 - k) % 10)}));
      check("t1_stat", status(), (k == 12) ? 3'b011 : 3'b100);
    end
    step(1);
    check("t1_done_val", value(), 8'h00);
    check("t1_done_stat", status(), 3'b010);
    step(5);
    check("t1_done_hold", status(), 3'b010);

    // Pause after 2 divider cycles; resumes with the same remaining count.
    start(4'd0, 4'd5);
    check("t2_load", value(), 8'h05);
    step(2);
    ifc.Pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("t2_paused_val", value(), 8'h05);
      check("t2_paused_stat", status(), 3'b000);
    end
    ifc.Pause = 1'b0;
    step(1);
    check("t2_resume_val", value(), 8'h05);
    check("t2_resume_stat", status(), 3'b100);
    step(1);
    check("t2_tick", value(), 8'h04);

    // Zero load goes straight to DONE.
    start(4'd0, 4'd0);
    check("t3_val", value(), 8'h00);
    check("t3_stat", status(), 3'b011);
    step(1);
    check("t3_stat2", status(), 3'b010);

    // Clamping and the 90 -> 89 borrow.
    start(4'hA, 4'hF);
    check("t4_clamp", value(), 8'h99);
    step(4);
    check("t4_tick", value(), 8'h98);
    start(4'hC, 4'd0);
    check("t4_clamp_tens", value(), 8'h90);
    step(4);
    check("t4_borrow", value(), 8'h89);
    start(4'd3, 4'hB);
    check("t4_clamp_ones", value(), 8'h39);

    // Restart while running mid-divider.
    start(4'd0, 4'd7);
    step(2);
    check("t5_run_val", value(), 8'h07);
    start(4'd3, 4'd0);
    check("t5_restart_val", value(), 8'h30);
    check("t5_restart_stat", status(), 3'b100);
    step(3);
    check("t5_reload_hold", value(), 8'h30);
    step(1);
    check("t5_reload_tick", value(), 8'h29);

    // Restart from DONE.
    start(4'd0, 4'd1);
    step(4);
    check("t5_done_stat", status(), 3'b011);
    step(1);
    start(4'd3, 4'd0);
    check("t5_from_done_val", value(), 8'h30);
    check("t5_from_done_stat", status(), 3'b100);

    // Async reset mid-count at 15.
    start(4'd1, 4'd5);
    step(2);
    check("t6_pre", value(), 8'h15);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_val", value(), 8'h00);
    check("t6_async_stat", status(), 3'b000);
    step(2);
    check("t6_held_stat", status(), 3'b000);
    #2;
    rst = 1'b0;
    step(1);
    start(4'd1, 4'd2);
    check("t6_restart", value(), 8'h12);
    step(3);
    check("t6_hold", value(), 8'h12);
    step(1);
    check("t6_tick", value(), 8'h11);
    check("t6_stat", status(), 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
